// File: rtl/dmem_responder_if.sv
// Request/response channel between a pipeline data-memory port and its responder.
// The master modport is the requester side; the slave modport is the memory side.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_rw;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_rw, req_size, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_rw, req_size, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store in flight, fixed access latency,
// byte/half/word lane handling, zero-extended loads, error flagging.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a request (req_ready high)
// WAIT  | request latched, latency down-counter running
// RESP  | result registered, rsp_valid held until rsp_ready
module dmem_responder #(
    parameter logic [31:0] BASE    = 32'h0100_0000,
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic            clock,
    input  logic            reset,
    dmem_responder_if.slave bus
);

    localparam int unsigned IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] LIMIT    = {1'b0, BASE} + 33'(DEPTH) * 33'd4;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        rw_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic [31:0] rdata_out;
    logic        err_out;

    logic [31:0] mem [DEPTH];

    logic        req_err;
    logic        commit;
    logic        commit_we;
    logic        c_rw;
    logic [1:0]  c_size;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic        c_err;
    logic [IW-1:0] c_idx;
    logic [1:0]  lane;
    logic [3:0]  wmask;
    logic [31:0] wdata_al;
    logic [31:0] rword;
    logic [31:0] rshift;
    logic [31:0] rdata_sel;

    function automatic logic addr_error(input logic [1:0] size, input logic [31:0] addr);
        logic [32:0] a;
        a = {1'b0, addr};
        return (size == 2'b11)
            || (size == 2'b01 && addr[0])
            || (size == 2'b10 && addr[1:0] != 2'b00)
            || (a < {1'b0, BASE})
            || (a >= LIMIT);
    endfunction

    assign req_err       = addr_error(bus.req_size, bus.req_addr);
    assign bus.req_ready = (state == ST_IDLE);
    assign bus.rsp_valid = (state == ST_RESP);
    assign bus.rsp_rdata = rdata_out;
    assign bus.rsp_err   = err_out;

    // Commit source and lane decode; with LATENCY==1 the commit edge is the accept edge,
    // so the live request fields are used instead of the latched copy.
    always_comb begin
        if (LATENCY == 1) begin
            c_rw    = bus.req_rw;
            c_size  = bus.req_size;
            c_addr  = bus.req_addr;
            c_wdata = bus.req_wdata;
            c_err   = req_err;
            commit  = (state == ST_IDLE) && bus.req_valid;
        end else begin
            c_rw    = rw_q;
            c_size  = size_q;
            c_addr  = addr_q;
            c_wdata = wdata_q;
            c_err   = err_q;
            commit  = (state == ST_WAIT) && (cnt == 4'd1);
        end
        commit_we = commit && c_rw && !c_err && !reset;
        c_idx     = IW'((c_addr - BASE) >> 2);
        lane      = c_addr[1:0];
        case (c_size)
            2'b00: begin
                wmask    = 4'b0001 << lane;
                wdata_al = {4{c_wdata[7:0]}};
            end
            2'b01: begin
                wmask    = c_addr[1] ? 4'b1100 : 4'b0011;
                wdata_al = {2{c_wdata[15:0]}};
            end
            default: begin
                wmask    = 4'b1111;
                wdata_al = c_wdata;
            end
        endcase
        rword  = mem[c_idx];
        rshift = rword >> {lane, 3'b000};
        case (c_size)
            2'b00:   rdata_sel = {24'h0, rshift[7:0]};
            2'b01:   rdata_sel = {16'h0, rshift[15:0]};
            default: rdata_sel = rword;
        endcase
    end

    // Storage write on the commit edge; contents survive reset.
    always_ff @(posedge clock) begin
        if (commit_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask[b]) begin
                    mem[c_idx][8*b +: 8] <= wdata_al[8*b +: 8];
                end
            end
        end
    end

    // Transaction FSM with latency counter and registered response.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            rw_q      <= 1'b0;
            size_q    <= 2'b00;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            err_q     <= 1'b0;
            rdata_out <= 32'h0;
            err_out   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        rw_q    <= bus.req_rw;
                        size_q  <= bus.req_size;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        err_q   <= req_err;
                        if (LATENCY == 1) begin
                            state <= ST_RESP;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            if (commit) begin
                rdata_out <= (c_err || c_rw) ? 32'h0 : rdata_sel;
                err_out   <= c_err;
            end
        end
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the pipeline's data-memory port: services one load/store at a time over a valid/ready request channel and a valid/ready response channel.
- Contains a word-organised storage array with a configurable fixed access latency.
- Performs byte/half/word lane selection and write masking.
- Returns zero-extended read data; the requester's writeback logic owns sign extension.
- Flags misaligned, bad-size and out-of-range accesses instead of touching storage.

Parameters:
BASE, 32'h01000000, byte address of word 0 of the array
DEPTH, 1024, number of 32-bit words in the array
LATENCY, 2, cycles from request acceptance to rsp_valid; legal values are 1..15

Ports:
clock  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request this cycle
req_rw  input  1  0 = read, 1 = write
req_size  input  2  00 byte, 01 half, 10 word, 11 illegal (matches funct3[1:0])
req_addr  input  32  byte address
req_wdata  input  32  store data, LSB-justified (byte in [7:0], half in [15:0])
rsp_valid  output  1  response present
rsp_ready  input  1  requester accepts the response
rsp_rdata  output  32  zero-extended load data; 0 for writes and errors
rsp_err  output  1  access rejected (misaligned, illegal size or out of range)

Behaviour:
- FSM states: IDLE, WAIT, RESP.
- req_ready = (state==IDLE), combinational. rsp_valid = (state==RESP).
- Reset (any state, including mid-transaction):
  - state goes to IDLE, counter = 0, rsp_rdata = 0, rsp_err = 0.
  - A pending write not yet committed is dropped.
  - Storage contents are not reset.
- Accept: on an edge with req_valid && req_ready, latch rw/size/addr/wdata and precompute the error flag.
  - If LATENCY==1, go to RESP; otherwise go to WAIT with counter = LATENCY-1.
- WAIT: decrement the counter each cycle; on the edge where the counter reaches 1, commit and go to RESP.
  - Result: rsp_valid rises exactly LATENCY cycles after the accept edge.
- Commit (the edge entering RESP):
  - Error: no storage change, rsp_rdata = 0, rsp_err = 1.
  - Write: update only the addressed byte lanes, rsp_rdata = 0, rsp_err = 0.
  - Read: rsp_rdata = selected lanes shifted to bit 0 and zero-extended, rsp_err = 0.
- RESP: hold rsp_valid, rsp_rdata and rsp_err stable until rsp_ready.
  - The edge with rsp_ready goes to IDLE.
  - No same-cycle turnaround: req_ready is low during RESP, so the next request is accepted one cycle later at the earliest.
- Error conditions:
  - size==11.
  - half with addr[0]==1.
  - word with addr[1:0]!=0.
  - addr < BASE, or addr >= BASE + 4*DEPTH.
- Indexing: word index = (addr-BASE)>>2; lane = addr[1:0].
  - Byte writes land in lane addr[1:0].
  - Half writes land in lanes addr[1]*2 +: 2.
- Only one transaction is outstanding at a time; reads always observe all previously committed writes.
- req_* inputs are ignored outside IDLE.
- rsp_ready is ignored outside RESP.

Test Plan:
- Reset, then word write 0xDEADBEEF to 0x01000010, then word read of 0x01000010 (LATENCY=2) -> rsp_valid 2 cycles after each accept; read rsp_rdata=0xDEADBEEF, rsp_err=0.
- Byte write 0x5A to 0x01000011 over 0xDEADBEEF, then reads of 0x01000010: word -> 0xDEAD5AEF; byte at 0x01000013 -> 0x000000DE; half at 0x01000012 -> 0x0000DEAD.
- Misaligned: half read at 0x01000001, word write at 0x01000006, size=11 -> each gives rsp_err=1, rsp_rdata=0; a following word read of 0x01000004 is unchanged.
- Out of range: read at 0x00FFFFFC and at 0x01001000 (DEPTH=1024) -> rsp_err=1.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_rdata stable and req_ready=0 throughout; the request is accepted the cycle after rsp_ready=1.
- Reset asserted during WAIT of a word write of 0x11111111 to 0x01000020 (holding 0x22222222) -> no response; req_ready=1 after reset; a read returns 0x22222222.
